booth_r4_mul: RTL and testbench

Parametrised sequential radix-4 Booth multiplier producing a 2W-bit product from two W-bit operands. It is the next generation of the team's 4×4 Booth multiplier and adds a configurable width, a start/busy/Fin handshake, a held result register, and an optional unsigned mode. It sits between an operand-issuing controller and any consumer of `result`, and processes one multiplication at a time.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_r4_recode.sv | 23 ++
 rtl/booth_r4_mul.sv | 178 +++++++++++++++++
 tb/tb_booth_r4_mul.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier.
// Honours the optional BOOTH_UNSIGNED_EN macro: when defined, one extra
// iteration is needed because the multiplier register is two bits wider.
package booth_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Radix-4 recoded partial-product selection.
  typedef enum logic [2:0] {
    ZERO = 3'b000,
    PM   = 3'b001,
    P2M  = 3'b010,
    MM   = 3'b011,
    M2M  = 3'b100
  } op_e;

  // Number of CALC iterations needed for a W-bit operand.
  function automatic int booth_iters(input int w);
`ifdef BOOTH_UNSIGNED_EN
    return (w / 2) + 1;
`else
    return w / 2;
`endif
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode: combinational radix-4 Booth digit recoder.
// Maps the bit triplet {q1, q0, q_-1} to the partial-product operation.
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] bits_i,
  output op_e        op_o
);

  // Triplet to operation lookup; 000/111 select nothing.
  always_comb begin
    op_o = ZERO;
    case (bits_i)
      3'b000, 3'b111: op_o = ZERO;
      3'b001, 3'b010: op_o = PM;
      3'b011:         op_o = P2M;
      3'b100:         op_o = M2M;
      3'b101, 3'b110: op_o = MM;
      default:        op_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// booth_r4_mul: sequential radix-4 Booth multiplier, W x W -> 2W.
// One multiplication at a time with a start/busy/Fin handshake; result is
// held until the next accepted operation completes.
// Optional macro BOOTH_UNSIGNED_EN adds a signed_op port selecting sign or
// zero extension of both operands (one extra iteration in both modes).
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int W = 8
)
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   multiplicando,
  input  logic [W-1:0]   multiplicador,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           signed_op,
`endif
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           Fin
);

  // Accumulator and multiplicand width; +-2M fits without overflow.
  localparam int AW = W + 2;
`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = W + 2;
`else
  localparam int QW = W;
`endif
  localparam int N     = booth_iters(W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int AHI   = 2 * W - QW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [AW-1:0]       a_q;
  logic [AW-1:0]       m_q;
  logic [QW-1:0]       q_q;
  logic                qm1_q;
  logic [2*W-1:0]      result_q;
  logic                busy_q;
  logic                fin_q;

  logic [AW-1:0]       a_d;
  logic [QW-1:0]       q_d;
  logic                qm1_d;
  logic [2*W-1:0]      result_d;

  logic [AW-1:0]       m_load_s;
  logic [QW-1:0]       q_load_s;
  logic                ext_s;
  op_e                 op_s;
  logic [AW-1:0]       addend_s;
  logic [AW-1:0]       opnd_s;
  logic                neg_s;
  logic [AW-1:0]       sum_s;

  booth_r4_recode u_recode (
    .bits_i ({q_q[1:0], qm1_q}),
    .op_o   (op_s)
  );

  // Operand extension applied when a start is accepted.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    ext_s    = signed_op;
    m_load_s = {{2{ext_s & multiplicando[W-1]}}, multiplicando};
    q_load_s = {{2{ext_s & multiplicador[W-1]}}, multiplicador};
`else
    ext_s    = 1'b1;
    m_load_s = {{2{ext_s & multiplicando[W-1]}}, multiplicando};
    q_load_s = multiplicador;
`endif
  end

  // One Booth step: select +-M/+-2M, add, then arithmetic shift by two.
  always_comb begin
    addend_s = {AW{1'b0}};
    neg_s    = 1'b0;
    case (op_s)
      ZERO: begin
        addend_s = {AW{1'b0}};
        neg_s    = 1'b0;
      end
      PM: begin
        addend_s = m_q;
        neg_s    = 1'b0;
      end
      P2M: begin
        addend_s = {m_q[AW-2:0], 1'b0};
        neg_s    = 1'b0;
      end
      MM: begin
        addend_s = m_q;
        neg_s    = 1'b1;
      end
      M2M: begin
        addend_s = {m_q[AW-2:0], 1'b0};
        neg_s    = 1'b1;
      end
      default: begin
        addend_s = {AW{1'b0}};
        neg_s    = 1'b0;
      end
    endcase
    // Subtraction is the inverted operand plus a carry-in of one.
    opnd_s   = neg_s ? ~addend_s : addend_s;
    sum_s    = a_q + opnd_s + {{(AW-1){1'b0}}, neg_s};
    a_d      = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    q_d      = {sum_s[1:0], q_q[QW-1:2]};
    qm1_d    = q_q[1];
    result_d = {a_d[AHI-1:0], q_d};
  end

  // Controller and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {AW{1'b0}};
      m_q      <= {AW{1'b0}};
      q_q      <= {QW{1'b0}};
      qm1_q    <= 1'b0;
      result_q <= {(2*W){1'b0}};
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fin_q <= 1'b0;
          if (start) begin
            a_q     <= {AW{1'b0}};
            m_q     <= m_load_s;
            q_q     <= q_load_s;
            qm1_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_q <= result_d;
            fin_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q  <= CALC;
          end
        end
        DONE: begin
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign Fin    = fin_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: directed, table-driven bench for booth_r4_mul at W=8 and
// an exhaustive signed sweep at W=4. Follows BOOTH_UNSIGNED_EN if defined.
module tb_booth_r4_mul;

`ifdef BOOTH_UNSIGNED_EN
  localparam int N8 = 5;
  localparam int N4 = 3;
`else
  localparam int N8 = 4;
  localparam int N4 = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st8, st4;
  logic [7:0]  mc8, mr8;
  logic [3:0]  mc4, mr4;
  logic [15:0] res8;
  logic [7:0]  res4;
  logic        busy8, busy4, fin8, fin4;
`ifdef BOOTH_UNSIGNED_EN
  logic        sop8, sop4;
`endif

  int n_vec = 0;
  int n_err = 0;

  booth_r4_mul #(.W(8)) dut8 (
    .clk           (clk),
    .reset         (reset),
    .start         (st8),
    .multiplicando (mc8),
    .multiplicador (mr8),
`ifdef BOOTH_UNSIGNED_EN
    .signed_op     (sop8),
`endif
    .result        (res8),
    .busy          (busy8),
    .Fin           (fin8)
  );

  booth_r4_mul #(.W(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .start         (st4),
    .multiplicando (mc4),
    .multiplicador (mr4),
`ifdef BOOTH_UNSIGNED_EN
    .signed_op     (sop4),
`endif
    .result        (res4),
    .busy          (busy4),
    .Fin           (fin4)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full W=8 transaction with latency, busy-width, single-Fin and hold checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string nm);
    int fin_at;
    int busy_n;
    int fin_n;
    @(negedge clk);
    mc8 = a; mr8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    fin_at = -1; busy_n = 0; fin_n = 0;
    if (busy8) busy_n++;
    for (int k = 1; k <= N8 + 3; k++) begin
      @(posedge clk); #1;
      if (busy8) busy_n++;
      if (fin8) begin
        fin_n++;
        if (fin_at < 0) begin
          fin_at = k;
          chk({nm, "_result"}, 32'(res8), 32'(exp));
        end
      end
    end
    chk({nm, "_latency"}, 32'(fin_at), 32'(N8));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(N8 + 1));
    chk({nm, "_fin_pulses"}, 32'(fin_n), 32'd1);
    chk({nm, "_hold"}, 32'(res8), 32'(exp));
  endtask

  // W=4 transaction: result and latency only.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int fin_at;
    @(negedge clk);
    mc4 = a; mr4 = b; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    fin_at = -1;
    for (int k = 1; k <= N4 + 3; k++) begin
      @(posedge clk); #1;
      if (fin4 && fin_at < 0) begin
        fin_at = k;
        chk($sformatf("w4_%0d_x_%0d", a, b), 32'(res4), 32'(exp));
      end
    end
    chk($sformatf("w4_lat_%0d_x_%0d", a, b), 32'(fin_at), 32'(N4));
  endtask

  initial begin
    int fin_n;
    int last;
    int ea;
    int eb;

    tbl[0] = '{a: 8'h07, b: 8'hFD, p: 16'hFFEB};  //    7 x -3   = -21
    tbl[1] = '{a: 8'h80, b: 8'h80, p: 16'h4000};  // -128 x -128 = 16384
    tbl[2] = '{a: 8'h80, b: 8'h7F, p: 16'hC080};  // -128 x 127  = -16256
    tbl[3] = '{a: 8'h00, b: 8'hFF, p: 16'h0000};  //    0 x -1
    tbl[4] = '{a: 8'h7F, b: 8'h7F, p: 16'h3F01};  //  127 x 127  = 16129
    tbl[5] = '{a: 8'hFF, b: 8'hFF, p: 16'h0001};  //   -1 x -1
    tbl[6] = '{a: 8'h0C, b: 8'hF6, p: 16'hFF88};  //   12 x -10  = -120

    reset = 1'b1; st8 = 1'b0; st4 = 1'b0;
    mc8 = 8'h00; mr8 = 8'h00; mc4 = 4'h0; mr4 = 4'h0;
`ifdef BOOTH_UNSIGNED_EN
    sop8 = 1'b1; sop4 = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result8", 32'(res8), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_fin8", 32'(fin8), 32'd0);
    chk("reset_result4", 32'(res4), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));
    end

    // start held high: one product every N+2 cycles
    @(negedge clk);
    mc8 = 8'd5; mr8 = 8'd5; st8 = 1'b1;
    fin_n = 0; last = -1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (fin8) begin
        fin_n++;
        chk("cont_result", 32'(res8), 32'h0019);
        if (last >= 0) chk("cont_period", 32'(k - last), 32'(N8 + 2));
        else           chk("cont_first", 32'(k), 32'(N8));
        last = k;
      end
    end
    chk("cont_count", 32'(fin_n), 32'd3);
    @(negedge clk);
    st8 = 1'b0;
    repeat (N8 + 4) @(posedge clk);

    // start pulses in CALC and in DONE are ignored
    @(negedge clk);
    mc8 = 8'hFA; mr8 = 8'h09; st8 = 1'b1;   // -6 x 9 = -54
    @(posedge clk); #1;
    st8 = 1'b0;
    fin_n = 0;
    for (int k = 1; k <= N8 + 6; k++) begin
      @(negedge clk);
      st8 = (k == 2 || k == N8 + 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (fin8) begin
        fin_n++;
        chk("pulse_result", 32'(res8), 32'h0000FFCA);
      end
    end
    st8 = 1'b0;
    chk("pulse_fins", 32'(fin_n), 32'd1);
    chk("pulse_idle", 32'(busy8), 32'd0);

    // reset in CALC cycle 2 aborts the operation
    @(negedge clk);
    mc8 = 8'd3; mr8 = 8'd3; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_fin", 32'(fin8), 32'd0);
    chk("abort_result", 32'(res8), 32'd0);
    fin_n = 0;
    for (int k = 0; k < N8 + 3; k++) begin
      @(posedge clk); #1;
      if (fin8) fin_n++;
    end
    chk("abort_no_fin", 32'(fin_n), 32'd0);
    op8(8'h07, 8'hFD, 16'hFFEB, "post_abort");

`ifdef BOOTH_UNSIGNED_EN
    sop8 = 1'b0;
    op8(8'hFF, 8'hFF, 16'hFE01, "uns_255x255");
    sop8 = 1'b1;
    op8(8'hFF, 8'hFF, 16'h0001, "sgn_m1xm1");
`endif

    // W=4 exhaustive against a signed reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ea = (a >= 8) ? a - 16 : a;
        eb = (b >= 8) ? b - 16 : b;
        op4(4'(a), 4'(b), 8'(ea * eb));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
